gpio_packet_shifter: RTL and testbench
======================================

GPIO_PACKET_SHIFTER -- requirements
Module: gpio_packet_shifter

Interface
REQ-001 SHALL have parameter PKT_W, default 56: packet width in bits (chip_select bit at MSB).
REQ-002 SHALL have parameter RD_W, default 32: readback word width.
REQ-003 SHALL have port clk_in  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port sdi  input  1  serial packet data, MSB first.
REQ-006 SHALL have port sin_en  input  1  qualifies sdi; one bit is taken per clk_in cycle with sin_en=1.
REQ-007 SHALL have port sout_req  input  1  request to serialize sram_data out.
REQ-008 SHALL have port sram_data  input  RD_W  registered SRAM readback word from the testchip core.
REQ-009 SHALL have port gpio_packet  output  PKT_W  last complete packet, registered; feeds the testchip core packet input.
REQ-010 SHALL have port packet_valid  output  1  one-cycle pulse when gpio_packet updates.
REQ-011 SHALL have port sdo  output  1  serial readback data, MSB first.
REQ-012 SHALL have port sout_busy  output  1  high while readback shifting.
REQ-013 SHALL have port parity_err  output  1  one-cycle pulse on a rejected packet.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT_IN, SHIFT_OUT.
REQ-015 In IDLE with sin_en=1: SHALL capture sdi as bit 1, set bit count to 1, go to SHIFT_IN; sin_en has priority over a simultaneous sout_req.
REQ-016 In IDLE with sin_en=0 and sout_req=1: SHALL load sram_data into the output shift register, go to SHIFT_OUT.
REQ-017 In SHIFT_IN: each cycle with sin_en=1 SHALL shift sdi into the shift-register LSB and increment the count; sin_en=0 stalls with all state held, no timeout.
REQ-018 When the count reaches the frame length (PKT_W, or PKT_W+1 with parity): SHALL, on the edge that samples the last bit, update gpio_packet, pulse packet_valid for exactly one cycle, and return to IDLE.
REQ-019 The first bit received SHALL land in gpio_packet[PKT_W-1]; the PKT_W-th bit SHALL land in gpio_packet[0].
REQ-020 gpio_packet SHALL hold its value between complete frames; partial frames SHALL never alter it.
REQ-021 In SHIFT_OUT: sdo SHALL present shift-register MSB; the register SHALL shift left once per cycle for RD_W cycles; sout_busy=1 throughout; sin_en and sout_req ignored.
REQ-022 First readback bit (sram_data[RD_W-1]) SHALL appear on sdo the cycle after the loading edge; after RD_W bits, the FSM SHALL return to IDLE with sdo=0 and sout_busy=0.
REQ-023 A sout_req held high SHALL start a new readback only after one IDLE cycle.
REQ-024 The bit counter SHALL be wide enough for PKT_W+1 with no wrap-around.

Reset
REQ-025 rst=1 SHALL force IDLE, clear count and both shift registers, and set gpio_packet=0, packet_valid=0, sdo=0, sout_busy=0, parity_err=0.
REQ-026 rst asserted mid-frame or mid-readback SHALL discard the partial operation; there SHALL be no packet_valid pulse.

Configuration
REQ-027 Macro PARITY_CHECK_EN defined: frame SHALL be PKT_W+1 bits, with the final bit odd parity over all PKT_W data bits.
REQ-028 On parity mismatch: gpio_packet SHALL be unchanged, packet_valid SHALL stay 0, parity_err SHALL pulse one cycle, and the FSM SHALL return to IDLE.
REQ-029 PARITY_CHECK_EN undefined: frame SHALL be PKT_W bits and parity_err SHALL be constant 0.

Verification
REQ-030 Reset, then shift 56 bits of 0x80_0000_0000_1234 with sin_en continuous -> gpio_packet=0x80000000001234 and packet_valid high one cycle on the 56th edge.
REQ-031 Same packet with sin_en low for 5 cycles after bit 20 -> identical result, delivered 5 cycles later; no intermediate gpio_packet change.
REQ-032 sram_data=0xA5A5_0F0F, sout_req pulse in IDLE -> sdo sequence 1,0,1,0,0,1,0,1,... over 32 cycles; sout_busy high 32 cycles.
REQ-033 sin_en and sout_req asserted in the same IDLE cycle -> SHIFT_IN entered, sout_busy stays 0.
REQ-034 rst asserted after bit 30 of a frame, then a full new packet 0x00_0000_0000_00FF -> gpio_packet=0xFF with exactly one packet_valid pulse.
REQ-035 With PARITY_CHECK_EN: 0x1 plus wrong parity bit 1 -> parity_err pulse, gpio_packet unchanged; correct parity 0 -> gpio_packet=0x1.

Source files
------------

// File: rtl/gpio_packet_shifter.sv
// rtl/gpio_packet_shifter.sv - serial packet capture and SRAM readback shifter; optional frame parity via PARITY_CHECK_EN
module gpio_packet_shifter #(
    parameter int PKT_W = 56,
    parameter int RD_W  = 32
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sdi,
    input  logic             sin_en,
    input  logic             sout_req,
    input  logic [RD_W-1:0]  sram_data,
    output logic [PKT_W-1:0] gpio_packet,
    output logic             packet_valid,
    output logic             sdo,
    output logic             sout_busy,
    output logic             parity_err
);

`ifdef PARITY_CHECK_EN
    localparam int FRAME_LEN = PKT_W + 1;
`else
    localparam int FRAME_LEN = PKT_W;
`endif
    // Counter spans up to PKT_W+1 regardless of build so it can never wrap.
    localparam int CNT_W  = $clog2(PKT_W + 2);
    localparam int OCNT_W = $clog2(RD_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT_IN, SHIFT_OUT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [OCNT_W-1:0] out_cnt;
    logic [PKT_W-1:0]  in_sreg;
    logic [RD_W-1:0]   out_sreg;
    logic              last_bit;
    logic              last_out;
    logic              frame_ok;
    logic [PKT_W-1:0]  frame_data;

    assign last_bit = (state == SHIFT_IN) && sin_en && (bit_cnt == CNT_W'(FRAME_LEN - 1));
    assign last_out = (state == SHIFT_OUT) && (out_cnt == OCNT_W'(RD_W - 1));

`ifdef PARITY_CHECK_EN
    // The final bit is the parity bit itself; data bits are already in in_sreg.
    assign frame_data = in_sreg;
    assign frame_ok   = (^in_sreg) ^ sdi;
`else
    // The final bit is the data LSB and is merged straight into the packet.
    assign frame_data = {in_sreg[PKT_W-2:0], sdi};
    assign frame_ok   = 1'b1;
`endif

    // State register
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; serial input wins over a simultaneous readback request
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sin_en) begin
                    state_nxt = SHIFT_IN;
                end else if (sout_req) begin
                    state_nxt = SHIFT_OUT;
                end
            end
            SHIFT_IN: begin
                if (last_bit) begin
                    state_nxt = IDLE;
                end
            end
            SHIFT_OUT: begin
                if (last_out) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Readback outputs are driven only while shifting out
    always_comb begin
        sout_busy = (state == SHIFT_OUT);
        sdo       = (state == SHIFT_OUT) ? out_sreg[RD_W-1] : 1'b0;
    end

    // Shift registers, counters and the registered packet/strobe outputs
    always_ff @(posedge clk_in) begin
        if (rst) begin
            bit_cnt      <= '0;
            out_cnt      <= '0;
            in_sreg      <= '0;
            out_sreg     <= '0;
            gpio_packet  <= '0;
            packet_valid <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            packet_valid <= 1'b0;
            parity_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sin_en) begin
                        in_sreg <= {{(PKT_W-1){1'b0}}, sdi};
                        bit_cnt <= CNT_W'(1);
                    end else if (sout_req) begin
                        out_sreg <= sram_data;
                        out_cnt  <= '0;
                    end
                end
                SHIFT_IN: begin
                    if (last_bit) begin
                        bit_cnt <= '0;
                        if (frame_ok) begin
                            gpio_packet  <= frame_data;
                            packet_valid <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end else if (sin_en) begin
                        in_sreg <= {in_sreg[PKT_W-2:0], sdi};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                SHIFT_OUT: begin
                    out_sreg <= {out_sreg[RD_W-2:0], 1'b0};
                    out_cnt  <= last_out ? '0 : out_cnt + OCNT_W'(1);
                end
                default: begin
                    bit_cnt <= '0;
                    out_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_packet_shifter.sv
// tb/tb_gpio_packet_shifter.sv - self-checking bench for gpio_packet_shifter
module tb_gpio_packet_shifter;

    localparam int PKT_W = 56;
    localparam int RD_W  = 32;
`ifdef PARITY_CHECK_EN
    localparam int FRAME = PKT_W + 1;
`else
    localparam int FRAME = PKT_W;
`endif

    logic             clk_in;
    logic             rst;
    logic             sdi;
    logic             sin_en;
    logic             sout_req;
    logic [RD_W-1:0]  sram_data;
    logic [PKT_W-1:0] gpio_packet;
    logic             packet_valid;
    logic             sdo;
    logic             sout_busy;
    logic             parity_err;

    gpio_packet_shifter #(.PKT_W(PKT_W), .RD_W(RD_W)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .sdi         (sdi),
        .sin_en      (sin_en),
        .sout_req    (sout_req),
        .sram_data   (sram_data),
        .gpio_packet (gpio_packet),
        .packet_valid(packet_valid),
        .sdo         (sdo),
        .sout_busy   (sout_busy),
        .parity_err  (parity_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int last_valid_cyc = 0;
    int valid_cnt = 0;
    int perr_cnt  = 0;
    int busy_total = 0;
    bit armed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: frame bits collected in a queue, readback bits queued for sdo
    bit               rx_q[$];
    bit               tx_q[$];
    logic [PKT_W-1:0] m_pkt;
    logic             m_valid;
    logic             m_perr;
    logic [PKT_W-1:0] m_data;
    int               m_ones;
    bit               m_idle;

    always @(posedge clk_in) begin
        cyc++;
        if (rst) begin
            rx_q.delete();
            tx_q.delete();
            m_pkt   = '0;
            m_valid = 1'b0;
            m_perr  = 1'b0;
        end else begin
            m_idle  = (rx_q.size() == 0) && (tx_q.size() == 0);
            m_valid = 1'b0;
            m_perr  = 1'b0;
            if (tx_q.size() > 0) tx_q.delete(0);
            if (m_idle && sin_en) begin
                rx_q.push_back(sdi);
            end else if (m_idle && sout_req) begin
                for (int i = RD_W - 1; i >= 0; i--) tx_q.push_back(sram_data[i]);
            end else if (rx_q.size() > 0 && sin_en) begin
                rx_q.push_back(sdi);
                if (rx_q.size() == FRAME) begin
                    m_ones = 0;
                    for (int i = 0; i < FRAME; i++) m_ones += int'(rx_q[i]);
                    for (int i = 0; i < PKT_W; i++) m_data[PKT_W-1-i] = rx_q[i];
                    if (FRAME == PKT_W || (m_ones % 2) == 1) begin
                        m_pkt   = m_data;
                        m_valid = 1'b1;
                    end else begin
                        m_perr = 1'b1;
                    end
                    rx_q.delete();
                end
            end
        end
    end

    // Compare every output against the reference each cycle, and tally events
    always @(negedge clk_in) begin
        if (armed) begin
            check("gpio_packet", 64'(gpio_packet), 64'(m_pkt));
            check("packet_valid", 64'(packet_valid), 64'(m_valid));
            check("parity_err", 64'(parity_err), 64'(m_perr));
            check("sout_busy", 64'(sout_busy), 64'(tx_q.size() > 0));
            check("sdo", 64'(sdo), 64'((tx_q.size() > 0) ? tx_q[0] : 1'b0));
            if (packet_valid === 1'b1) begin
                valid_cnt++;
                last_valid_cyc = cyc;
            end
            if (parity_err === 1'b1) perr_cnt++;
            if (sout_busy === 1'b1) busy_total++;
        end
    end

    function automatic logic [63:0] frame_of(input logic [PKT_W-1:0] p);
`ifdef PARITY_CHECK_EN
        return {7'b0, p, ~^p};
`else
        return {8'b0, p};
`endif
    endfunction

    task automatic send_frame(input logic [63:0] bits, input int nbits, input int stall_after,
                              input int stall_len, input logic req_first);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk_in);
            if (i == 0) start_cyc = cyc;
            sin_en   = 1'b1;
            sdi      = bits[nbits-1-i];
            sout_req = (i == 0) ? req_first : 1'b0;
            if (stall_after > 0 && i + 1 == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk_in);
                    sin_en   = 1'b0;
                    sout_req = 1'b0;
                end
            end
        end
        @(negedge clk_in);
        sin_en   = 1'b0;
        sdi      = 1'b0;
        sout_req = 1'b0;
    endtask

    int          v0;
    int          p0;
    int          b0;
    int          lat_a;
    int          bcnt;
    logic [31:0] rb;

    initial begin
        rst = 1'b1; sin_en = 1'b0; sdi = 1'b0; sout_req = 1'b0; sram_data = '0;
        repeat (2) @(negedge clk_in);
        armed = 1;
        check("reset_gpio", 64'(gpio_packet), 64'h0);
        check("reset_valid", 64'(packet_valid), 64'h0);
        check("reset_sdo", 64'(sdo), 64'h0);
        check("reset_busy", 64'(sout_busy), 64'h0);
        check("reset_perr", 64'(parity_err), 64'h0);
        rst = 1'b0;

        // Continuous frame
        v0 = valid_cnt;
        send_frame(frame_of(56'h80_0000_0000_1234), FRAME, 0, 0, 1'b0);
        @(negedge clk_in);
        check("t1_pkt", 64'(gpio_packet), 64'h0080_0000_0000_1234);
        check("t1_pulses", 64'(valid_cnt - v0), 64'd1);
        lat_a = last_valid_cyc - start_cyc;
        check("t1_latency", 64'(lat_a), 64'(FRAME));

        // Same frame stalled 5 cycles after bit 20
        v0 = valid_cnt;
        send_frame(frame_of(56'h80_0000_0000_1234), FRAME, 20, 5, 1'b0);
        @(negedge clk_in);
        check("t2_pkt", 64'(gpio_packet), 64'h0080_0000_0000_1234);
        check("t2_pulses", 64'(valid_cnt - v0), 64'd1);
        check("t2_latency", 64'(last_valid_cyc - start_cyc), 64'(lat_a + 5));

        // Readback of 0xA5A5_0F0F
        @(negedge clk_in);
        sram_data = 32'hA5A5_0F0F;
        sout_req  = 1'b1;
        @(negedge clk_in);
        sout_req = 1'b0;
        rb = '0;
        bcnt = 0;
        for (int i = 0; i < RD_W; i++) begin
            if (i > 0) @(negedge clk_in);
            rb = {rb[30:0], sdo};
            bcnt += int'(sout_busy);
        end
        check("t3_sdo_seq", 64'(rb), 64'hA5A5_0F0F);
        check("t3_busy_cycles", 64'(bcnt), 64'd32);
        @(negedge clk_in);
        check("t3_busy_end", 64'(sout_busy), 64'h0);
        check("t3_sdo_end", 64'(sdo), 64'h0);

        // sin_en and sout_req together in IDLE
        b0 = busy_total;
        v0 = valid_cnt;
        send_frame(frame_of(56'h12_3456_789A_BCDE), FRAME, 0, 0, 1'b1);
        @(negedge clk_in);
        check("t4_no_busy", 64'(busy_total - b0), 64'd0);
        check("t4_pkt", 64'(gpio_packet), 64'h0012_3456_789A_BCDE);
        check("t4_pulses", 64'(valid_cnt - v0), 64'd1);

        // sout_req held high: back-to-back readbacks separated by an IDLE cycle
        sram_data = 32'h8000_0001;
        sout_req  = 1'b1;
        repeat (70) @(negedge clk_in);
        sout_req = 1'b0;
        repeat (40) @(negedge clk_in);

        // Reset after bit 30, then a fresh 0xFF packet
        send_frame(64'h3FFF_FFFF, 30, 0, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        v0 = valid_cnt;
        send_frame(frame_of(56'h00_0000_0000_00FF), FRAME, 0, 0, 1'b0);
        @(negedge clk_in);
        check("t6_pkt", 64'(gpio_packet), 64'h0000_0000_0000_00FF);
        check("t6_pulses", 64'(valid_cnt - v0), 64'd1);

`ifdef PARITY_CHECK_EN
        // Wrong parity is rejected, correct parity accepted
        v0 = valid_cnt;
        p0 = perr_cnt;
        send_frame({7'b0, 56'h1, 1'b1}, FRAME, 0, 0, 1'b0);
        @(negedge clk_in);
        check("t7_bad_pkt", 64'(gpio_packet), 64'hFF);
        check("t7_bad_perr", 64'(perr_cnt - p0), 64'd1);
        check("t7_bad_valid", 64'(valid_cnt - v0), 64'd0);
        send_frame({7'b0, 56'h1, 1'b0}, FRAME, 0, 0, 1'b0);
        @(negedge clk_in);
        check("t7_good_pkt", 64'(gpio_packet), 64'h1);
        check("t7_good_valid", 64'(valid_cnt - v0), 64'd1);
`else
        p0 = perr_cnt;
`endif

        // All-ones packet
        send_frame(frame_of({PKT_W{1'b1}}), FRAME, 0, 0, 1'b0);
        @(negedge clk_in);
        check("t8_pkt", 64'(gpio_packet), 64'h00FF_FFFF_FFFF_FFFF);
`ifndef PARITY_CHECK_EN
        check("t8_no_perr", 64'(perr_cnt - p0), 64'd0);
`endif
        repeat (3) @(negedge clk_in);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
